// File: rtl/eth_udp_recv.sv
// eth_udp_recv: parses an IPv4 + UDP header from a MAC-stripped byte stream, validates it,
// and writes the UDP payload into the rx FIFO with a single done/err pulse per packet.
module eth_udp_recv #(
   parameter bit CHECK_IP_CSUM = 1'b1,
   parameter bit ACCEPT_BCAST  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] local_ip,
   input  logic [15:0] local_port,
   input  logic        ip_valid,
   input  logic        ip_sop,
   input  logic        ip_eop,
   input  logic [7:0]  ip_data,
   input  logic        wfifo_full,
   output logic        wfifo_wr_en,
   output logic [7:0]  wfifo_wr_data,
   output logic [31:0] rx_src_ip,
   output logic [15:0] rx_src_port,
   output logic [15:0] rx_udp_data_len,
   output logic        recv_done,
   output logic        recv_err,
   output logic [2:0]  err_code,
   output logic        busy
);
   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_HDR   = 3'd1;
   localparam logic [2:0] E_CSUM  = 3'd2;
   localparam logic [2:0] E_IP    = 3'd3;
   localparam logic [2:0] E_PORT  = 3'd4;
   localparam logic [2:0] E_LEN   = 3'd5;
   localparam logic [2:0] E_TRUNC = 3'd6;
   localparam logic [2:0] E_OVF   = 3'd7;

   typedef enum logic [2:0] {IDLE, IP_HDR, UDP_HDR, UDP_DATA, DROP} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [19:0] acc;
   logic [7:0]  prev;
   logic [15:0] ip_len;
   logic [15:0] udp_len;
   logic [15:0] src_port;
   logic [31:0] src_ip;
   logic [23:0] dst_ip;

   logic [15:0] word;
   logic [19:0] csum_sum;
   logic [19:0] csum_fold;
   logic [31:0] dst_full;
   logic        csum_ok;
   logic        ip_ok;
   logic        in_pkt;
   logic        last;
   logic [2:0]  fault;

   function automatic logic [19:0] fold(input logic [19:0] x);
      return {4'd0, x[15:0]} + {16'd0, x[19:16]};
   endfunction

   // Header fields are big-endian 16-bit words: previous byte is the high half.
   assign word      = {prev, ip_data};
   assign csum_sum  = acc + {4'd0, word};
   assign csum_fold = fold(fold(csum_sum));
   assign csum_ok   = (csum_fold == 20'h0FFFF);
   assign dst_full  = {dst_ip, ip_data};
   assign ip_ok     = (dst_full == local_ip) || (ACCEPT_BCAST && (dst_full == 32'hFFFF_FFFF));
   assign in_pkt    = (state == IP_HDR) || (state == UDP_HDR) || (state == UDP_DATA);
   assign busy      = (state != IDLE);

   always_comb begin
      fault = E_NONE;
      last  = 1'b0;
      case (state)
         IP_HDR: begin
            last = (cnt == 16'd19);
            case (cnt)
               16'd3:  if (word < 16'd28) fault = E_LEN;
               16'd7:  if (prev[5] || ({prev[4:0], ip_data} != 13'd0)) fault = E_HDR;
               16'd9:  if (ip_data != 8'h11) fault = E_HDR;
               16'd19: begin
                  if (CHECK_IP_CSUM && !csum_ok) fault = E_CSUM;
                  else if (!ip_ok)               fault = E_IP;
               end
               default: ;
            endcase
         end
         UDP_HDR: begin
            last = (cnt == 16'd7);
            case (cnt)
               16'd3: if (word != local_port) fault = E_PORT;
               16'd5: if ((word < 16'd8) || (word > (ip_len - 16'd20))) fault = E_LEN;
               default: ;
            endcase
         end
         UDP_DATA: begin
            last = (cnt == (udp_len - 16'd9));
            if (wfifo_full) fault = E_OVF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         acc             <= '0;
         wfifo_wr_en     <= 1'b0;
         wfifo_wr_data   <= '0;
         rx_src_ip       <= '0;
         rx_src_port     <= '0;
         rx_udp_data_len <= '0;
         recv_done       <= 1'b0;
         recv_err        <= 1'b0;
         err_code        <= '0;
      end else begin
         wfifo_wr_en <= 1'b0;
         recv_done   <= 1'b0;
         recv_err    <= 1'b0;
         if (ip_valid && ip_sop) begin
            // A sop inside a live packet truncates it; the sop byte still opens the next one.
            if (in_pkt) begin
               recv_err <= 1'b1;
               err_code <= E_TRUNC;
            end
            cnt <= 16'd1;
            acc <= '0;
            if ((ip_data != 8'h45) || ip_eop) begin
               state <= ip_eop ? IDLE : DROP;
               if (!in_pkt) begin
                  recv_err <= 1'b1;
                  err_code <= (ip_data != 8'h45) ? E_HDR : E_TRUNC;
               end
            end else begin
               state <= IP_HDR;
            end
         end else if (ip_valid) begin
            case (state)
               IDLE: ;
               DROP: if (ip_eop) state <= IDLE;
               default: begin
                  if ((state == UDP_DATA) && !wfifo_full) begin
                     wfifo_wr_en   <= 1'b1;
                     wfifo_wr_data <= ip_data;
                  end
                  if ((state == IP_HDR) && cnt[0]) acc <= csum_sum;
                  cnt <= cnt + 16'd1;
                  if (fault != E_NONE) begin
                     recv_err <= 1'b1;
                     err_code <= fault;
                     cnt      <= '0;
                     state    <= ip_eop ? IDLE : DROP;
                  end else if (last && ((state == UDP_DATA) ||
                                        ((state == UDP_HDR) && (udp_len == 16'd8)))) begin
                     recv_done       <= 1'b1;
                     rx_src_ip       <= src_ip;
                     rx_src_port     <= src_port;
                     rx_udp_data_len <= udp_len - 16'd8;
                     cnt             <= '0;
                     state           <= ip_eop ? IDLE : DROP;
                  end else if (ip_eop) begin
                     recv_err <= 1'b1;
                     err_code <= E_TRUNC;
                     cnt      <= '0;
                     state    <= IDLE;
                  end else if (last) begin
                     cnt   <= '0;
                     state <= (state == IP_HDR) ? UDP_HDR : UDP_DATA;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ip_valid) begin
         prev <= ip_data;
         if (!ip_sop && (state == IP_HDR)) begin
            if (cnt == 16'd3) ip_len <= word;
            if ((cnt >= 16'd12) && (cnt <= 16'd15)) src_ip <= {src_ip[23:0], ip_data};
            if (cnt >= 16'd16) dst_ip <= {dst_ip[15:0], ip_data};
         end
         if (!ip_sop && (state == UDP_HDR)) begin
            if (cnt == 16'd1) src_port <= word;
            if (cnt == 16'd5) udp_len  <= word;
         end
      end
   end
endmodule
